// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding and burst-counter width for the UART TX arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arbState_e;
  localparam int BurstCntWidth = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit searching ptr+1, ptr+2, ... modulo N
//   req : request vector
//   ptr : index of the last winner (lowest priority)
//   gnt : one-hot winner, zero when no request
//   vld : any request present
module rr_pick #(
  parameter int N = 2,
  parameter int PtrWidth = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [PtrWidth-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic                vld
);
  logic [PtrWidth-1:0] idx;
  // Walk from the farthest candidate to the nearest so the nearest valid one is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PtrWidth'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
  assign vld = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX ready/valid port
//   Clock/Reset                : clock, synchronous active-high reset
//   ReqData/ReqValid/ReqLast   : per-requester byte streams, ReqReady = accepted this cycle
//   DataIn/DataInValid         : byte to the UART, DataInReady = UART accepts
//   Grant                      : one-hot current owner, Busy = locked to an owner
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NumReq   = 2,
  parameter int MaxBurst = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [8*NumReq-1:0] ReqData,
  input  logic [NumReq-1:0]   ReqValid,
  input  logic [NumReq-1:0]   ReqLast,
  output logic [NumReq-1:0]   ReqReady,
  output logic [7:0]          DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  output logic [NumReq-1:0]   Grant,
  output logic                Busy
);
  localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  arbState_e state, nextState;
  logic [NumReq-1:0] grantQ, pickGnt;
  logic pickVld, ownerValid, ownerLast, xfer, lastXfer;
  logic [PtrWidth-1:0] ptr, owner;
  logic [7:0] ownerData;
  logic [BurstCntWidth-1:0] count;
  rr_pick #(.N(NumReq), .PtrWidth(PtrWidth)) picker (
    .req(ReqValid),
    .ptr(ptr),
    .gnt(pickGnt),
    .vld(pickVld)
  );
  // grantQ is zero whenever IDLE, so the owner mux yields nothing outside LOCKED.
  always_comb begin
    owner = '0;
    ownerData = '0;
    ownerValid = 1'b0;
    ownerLast = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (grantQ[i]) begin
        owner = PtrWidth'(i);
        ownerData = ReqData[i*8 +: 8];
        ownerValid = ReqValid[i];
        ownerLast = ReqLast[i];
      end
    end
  end
  assign xfer = ownerValid & DataInReady;
  assign lastXfer = xfer & (ownerLast | (count == BurstCntWidth'(MaxBurst - 1)));
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ARB_IDLE;
      grantQ <= '0;
      ptr <= PtrWidth'(NumReq - 1);
      count <= '0;
    end else begin
      state <= nextState;
      if (state == ARB_IDLE) begin
        grantQ <= pickGnt;
        count <= '0;
      end else if (lastXfer) begin
        grantQ <= '0;
        ptr <= owner;
      end else if (xfer) count <= count + 1'b1;
    end
  end
  always_comb nextState = (state == ARB_IDLE) ? (pickVld ? ARB_LOCKED : ARB_IDLE) : (lastXfer ? ARB_IDLE : ARB_LOCKED);
  always_comb begin
    Busy = (state == ARB_LOCKED);
    Grant = grantQ;
    DataIn = ownerData;
    DataInValid = ownerValid;
    ReqReady = grantQ & {NumReq{xfer}};
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with two queued requesters
module tb_uart_tx_arbiter;
  logic Clock = 1'b0;
  logic Reset, DataInReady, DataInValid, Busy;
  logic [15:0] ReqData;
  logic [1:0] ReqValid, ReqLast, ReqReady, Grant;
  logic [7:0] DataIn;
  int nCompared = 0, nMismatched = 0, cyc = 0, bad;
  logic [7:0] qd[2][$];
  bit ql[2][$];
  bit hold[2];
  logic [7:0] rx[$], expRx[$];
  int rxCyc[$];

  always #5 Clock = ~Clock;

  uart_tx_arbiter #(.NumReq(2), .MaxBurst(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqData(ReqData), .ReqValid(ReqValid), .ReqLast(ReqLast), .ReqReady(ReqReady),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .Grant(Grant), .Busy(Busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      ReqValid[i] = (qd[i].size() > 0) && !hold[i];
      ReqData[i*8 +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
      ReqLast[i] = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
  endtask

  task automatic push(int r, logic [7:0] d, bit l);
    qd[r].push_back(d);
    ql[r].push_back(l);
  endtask

  task automatic step();
    logic [1:0] rdy;
    @(negedge Clock);
    rdy = ReqReady;
    if (!Reset && DataInValid && DataInReady) begin
      rx.push_back(DataIn);
      rxCyc.push_back(cyc);
    end
    cyc++;
    @(posedge Clock);
    #1;
    for (int i = 0; i < 2; i++)
      if (rdy[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    drive();
    #1;
  endtask

  task automatic runIdle(string tag);
    int n = 0;
    while ((qd[0].size() > 0 || qd[1].size() > 0 || Busy) && n < 200) begin
      step();
      n++;
    end
    check(tag, (n >= 200) ? 1 : 0, 0);
  endtask

  task automatic checkRx(string tag);
    check({tag, "_count"}, rx.size(), expRx.size());
    for (int i = 0; i < expRx.size() && i < rx.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), rx[i], expRx[i]);
    rx.delete();
    rxCyc.delete();
    expRx.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    DataInReady = 1'b0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    drive();
    step();
    step();
    check("rst_grant", Grant, 0);
    check("rst_busy", Busy, 0);
    check("rst_valid", DataInValid, 0);
    check("rst_ready", ReqReady, 0);
    check("rst_data", DataIn, 0);
    Reset = 1'b0;

    push(0, 8'h41, 0);
    push(0, 8'h42, 1);
    DataInReady = 1'b1;
    drive();
    #1;
    check("t1_idle_valid", DataInValid, 0);
    check("t1_idle_ready", ReqReady, 0);
    step();
    check("t1_grant", Grant, 2'b01);
    check("t1_busy", Busy, 1);
    check("t1_data0", DataIn, 8'h41);
    check("t1_ready0", ReqReady, 2'b01);
    step();
    check("t1_data1", DataIn, 8'h42);
    check("t1_ready1", ReqReady, 2'b01);
    step();
    check("t1_release_grant", Grant, 0);
    check("t1_release_busy", Busy, 0);
    expRx.push_back(8'h41);
    expRx.push_back(8'h42);
    checkRx("t1_rx");

    for (int k = 0; k < 3; k++) begin
      push(0, 8'h10, 1);
      push(1, 8'h20, 1);
      expRx.push_back(8'h20);
      expRx.push_back(8'h10);
    end
    drive();
    for (int k = 0; k < 12; k++) step();
    check("t2_idle", Busy, 0);
    for (int k = 1; k < 6 && k < rxCyc.size(); k++)
      check($sformatf("t2_gap%0d", k), rxCyc[k] - rxCyc[k-1], 2);
    checkRx("t2_rx");

    for (int k = 0; k < 20; k++) begin
      push(0, 8'(k), k == 19);
      if (k < 16) expRx.push_back(8'(k));
    end
    expRx.push_back(8'hAA);
    for (int k = 16; k < 20; k++) expRx.push_back(8'(k));
    drive();
    step();
    check("t3_grant0", Grant, 2'b01);
    push(1, 8'hAA, 1);
    drive();
    runIdle("t3_timeout");
    checkRx("t3_rx");

    push(1, 8'h55, 0);
    push(1, 8'h66, 1);
    DataInReady = 1'b0;
    drive();
    step();
    check("t4_grant", Grant, 2'b10);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (DataInValid !== 1'b1 || DataIn !== 8'h55 || ReqReady !== 2'b00 || Grant !== 2'b10) bad++;
    end
    check("t4_stall_bad_cycles", bad, 0);
    check("t4_no_xfer", rx.size(), 0);
    DataInReady = 1'b1;
    drive();
    #1;
    check("t4_ready", ReqReady, 2'b10);
    step();
    check("t4_data1", DataIn, 8'h66);
    step();
    check("t4_release", Busy, 0);
    expRx.push_back(8'h55);
    expRx.push_back(8'h66);
    checkRx("t4_rx");

    push(1, 8'h77, 0);
    push(1, 8'h88, 1);
    drive();
    step();
    check("t5_grant", Grant, 2'b10);
    push(0, 8'h99, 1);
    drive();
    step();
    hold[1] = 1'b1;
    drive();
    #1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (Grant !== 2'b10 || DataInValid !== 1'b0 || ReqReady !== 2'b00) bad++;
      step();
    end
    check("t5_hold_bad_cycles", bad, 0);
    hold[1] = 1'b0;
    drive();
    #1;
    check("t5_resume_data", DataIn, 8'h88);
    check("t5_resume_valid", DataInValid, 1);
    runIdle("t5_timeout");
    expRx.push_back(8'h77);
    expRx.push_back(8'h88);
    expRx.push_back(8'h99);
    checkRx("t5_rx");

    push(1, 8'hA1, 0);
    push(1, 8'hA2, 0);
    push(1, 8'hA3, 1);
    drive();
    step();
    check("t6_grant1", Grant, 2'b10);
    step();
    DataInReady = 1'b0;
    Reset = 1'b1;
    push(0, 8'hB1, 1);
    drive();
    step();
    check("t6_rst_grant", Grant, 0);
    check("t6_rst_busy", Busy, 0);
    check("t6_rst_valid", DataInValid, 0);
    Reset = 1'b0;
    DataInReady = 1'b1;
    drive();
    step();
    check("t6_regrant", Grant, 2'b01);
    check("t6_regrant_data", DataIn, 8'hB1);
    runIdle("t6_timeout");
    expRx.push_back(8'hA1);
    expRx.push_back(8'hB1);
    expRx.push_back(8'hA2);
    expRx.push_back(8'hA3);
    checkRx("t6_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
